// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and the data memory.
// Handshake: the master raises dm_req with dm_addr/dm_we/dm_wdata and holds
// them stable until the slave returns dm_ack for one cycle. When the request
// is a read, dm_rdata must be valid in that same ack cycle. dm_ack outside an
// outstanding request carries no meaning and is ignored by the master.
interface mem_access_if #(
    parameter int N = 64
);
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/mem_access.sv
// Pipeline MEM stage: EX/MEM register plus a data-memory access sequencer.
// Memory operations hold the pipeline (stall_M) until the memory acks. A
// misaligned address or an ack timeout drops the block into a sticky FAULT
// state that only reset clears. The next E operation is captured on the same
// edge that completes an access, so back-to-back operations have no bubble.
module mem_access #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,

    // execute side
    input  logic         valid_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         Branch_E,
    input  logic         zero_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,

    // data memory
    mem_access_if.master dm,

    // writeback side
    output logic         valid_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,

    // status
    output logic         stall_M,
    output logic         err_M,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Last wait-counter value before an unacknowledged access times out.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t       state;
    logic [7:0]   wait_cnt;
    logic         mem_read_M;    // latched op is a pure read
    logic         mem_write_M;   // latched op is a write (wins over read)
    logic [N-1:0] write_data_M;
    logic         dm_req_q;

    logic         capture;
    logic         is_mem_E;
    logic         misaligned_E;
    logic         ack_done;

    // Stall while waiting for the memory, and forever once faulted.
    assign stall_M = ((state == ACCESS) && !dm.dm_ack) || (state == FAULT);

    // The EX/MEM register advances whenever nothing holds the pipeline.
    assign capture = !stall_M && (state != FAULT);

    assign is_mem_E     = valid_E && (MemRead_E || MemWrite_E);
    assign misaligned_E = (aluResult_E[2:0] != 3'b000);
    assign ack_done     = (state == ACCESS) && dm.dm_ack;

    // Memory bus is driven straight from the latched operation so it stays
    // stable for the whole access.
    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = mem_write_M;
    assign dm.dm_addr  = aluResult_M;
    assign dm.dm_wdata = write_data_M;

    assign state_dbg = state;

    // Access sequencer, EX/MEM register and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            valid_M      <= 1'b0;
            aluResult_M  <= '0;
            readData_M   <= '0;
            PCBranch_M   <= '0;
            PCSrc_M      <= 1'b0;
            err_M        <= 1'b0;
            mem_read_M   <= 1'b0;
            mem_write_M  <= 1'b0;
            write_data_M <= '0;
            dm_req_q     <= 1'b0;
        end else begin
            // A completing read returns its data; a completing write leaves
            // readData_M untouched.
            if (ack_done && mem_read_M) begin
                readData_M <= dm.dm_rdata;
            end

            if (capture) begin
                aluResult_M  <= aluResult_E;
                PCBranch_M   <= PCBranch_E;
                write_data_M <= writeData_E;
                mem_read_M   <= valid_E && MemRead_E && !MemWrite_E;
                mem_write_M  <= valid_E && MemWrite_E;

                if (is_mem_E && misaligned_E) begin
                    // Misaligned access never reaches the memory bus.
                    state    <= FAULT;
                    valid_M  <= 1'b0;
                    PCSrc_M  <= 1'b0;
                    err_M    <= 1'b1;
                    dm_req_q <= 1'b0;
                end else if (is_mem_E) begin
                    state    <= ACCESS;
                    wait_cnt <= 8'd0;
                    valid_M  <= valid_E;
                    PCSrc_M  <= valid_E && Branch_E && zero_E;
                    dm_req_q <= 1'b1;
                end else begin
                    state    <= IDLE;
                    valid_M  <= valid_E;
                    PCSrc_M  <= valid_E && Branch_E && zero_E;
                    dm_req_q <= 1'b0;
                end
            end else if (state == ACCESS) begin
                // Only reached without an ack: count the wait or give up.
                if (wait_cnt >= LAST_WAIT) begin
                    state    <= FAULT;
                    valid_M  <= 1'b0;
                    PCSrc_M  <= 1'b0;
                    err_M    <= 1'b1;
                    dm_req_q <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, branches, loads, stores,
// zero-bubble capture, ack timeout, misalignment fault and reset abandonment.
module tb_mem_access;

    localparam int N = 64;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_FAULT  = 2'd2;

    logic         clk;
    logic         reset;
    logic         valid_E, MemRead_E, MemWrite_E, Branch_E, zero_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
    logic         valid_M, PCSrc_M, stall_M, err_M;
    logic [N-1:0] aluResult_M, readData_M, PCBranch_M;
    logic [1:0]   state_dbg;

    mem_access_if #(.N(N)) dm_bus ();

    mem_access #(.N(N), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .Branch_E    (Branch_E),
        .zero_E      (zero_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .dm          (dm_bus.master),
        .valid_M     (valid_M),
        .aluResult_M (aluResult_M),
        .readData_M  (readData_M),
        .PCBranch_M  (PCBranch_M),
        .PCSrc_M     (PCSrc_M),
        .stall_M     (stall_M),
        .err_M       (err_M),
        .state_dbg   (state_dbg)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    // scoreboard
    logic [N-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=0x%0h expected=<empty queue>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic set_op(input logic v, input logic rd, input logic wr,
                          input logic br, input logic z, input logic [N-1:0] alu,
                          input logic [N-1:0] wd, input logic [N-1:0] pcb);
        valid_E = v; MemRead_E = rd; MemWrite_E = wr; Branch_E = br; zero_E = z;
        aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    int           req_cycles;
    int           stall_cycles;
    logic         req_seen;
    logic [N-1:0] r_alu, r_pcb, r_data;
    logic         r_br, r_z;

    initial begin
        reset = 1'b1;
        nop();
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = '0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_valid_M", 64'(valid_M), 64'd0);
        check("rst_PCSrc_M", 64'(PCSrc_M), 64'd0);
        check("rst_err_M", 64'(err_M), 64'd0);
        check("rst_dm_req", 64'(dm_bus.dm_req), 64'd0);
        check("rst_aluResult_M", aluResult_M, 64'd0);
        check("rst_readData_M", readData_M, 64'd0);
        check("rst_PCBranch_M", PCBranch_M, 64'd0);
        check("rst_state", 64'(state_dbg), 64'(S_IDLE));
        check("rst_stall_M", 64'(stall_M), 64'd0);
        reset = 1'b0;

        // plain ALU op, one-cycle latency
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2A, '0, '0);
        exp_q.push_back(64'h2A);
        @(negedge clk);
        nop();
        check_pop("alu_result_M", aluResult_M);
        check("alu_valid_M", 64'(valid_M), 64'd1);
        check("alu_stall_M", 64'(stall_M), 64'd0);
        check("alu_dm_req", 64'(dm_bus.dm_req), 64'd0);

        // branch taken, then not taken
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h7, '0, 64'h40);
        @(negedge clk);
        check("br_taken_PCSrc", 64'(PCSrc_M), 64'd1);
        check("br_taken_PCBranch", PCBranch_M, 64'h40);
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h7, '0, 64'h80);
        @(negedge clk);
        nop();
        check("br_not_taken_PCSrc", 64'(PCSrc_M), 64'd0);
        check("br_not_taken_PCBranch", PCBranch_M, 64'h80);

        // load 0x100 acked in third access cycle
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h100, '0, '0);
        exp_q.push_back(64'hDEADBEEF);
        @(negedge clk);
        nop();
        req_cycles = 0;
        stall_cycles = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                dm_bus.dm_ack   = 1'b1;
                dm_bus.dm_rdata = 64'hDEADBEEF;
            end
            #1;
            if (dm_bus.dm_req) req_cycles++;
            if (stall_M) stall_cycles++;
            check("ld_dm_addr", dm_bus.dm_addr, 64'h100);
            check("ld_dm_we", 64'(dm_bus.dm_we), 64'd0);
            @(negedge clk);
        end
        dm_bus.dm_ack = 1'b0;
        check("ld_req_cycles", 64'(req_cycles), 64'd3);
        check("ld_stall_cycles", 64'(stall_cycles), 64'd2);
        check_pop("ld_readData_M", readData_M);
        check("ld_dm_req_after", 64'(dm_bus.dm_req), 64'd0);
        check("ld_state_after", 64'(state_dbg), 64'(S_IDLE));

        // store 0x08 acked immediately, next op captured on the ack edge
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h08, 64'h55, '0);
        @(negedge clk);
        check("st_dm_req", 64'(dm_bus.dm_req), 64'd1);
        check("st_dm_we", 64'(dm_bus.dm_we), 64'd1);
        check("st_dm_wdata", dm_bus.dm_wdata, 64'h55);
        check("st_dm_addr", dm_bus.dm_addr, 64'h08);
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h77, '0, '0);
        exp_q.push_back(64'h77);
        dm_bus.dm_ack = 1'b1;
        #1;
        check("st_ack_stall_M", 64'(stall_M), 64'd0);
        @(negedge clk);
        dm_bus.dm_ack = 1'b0;
        nop();
        check_pop("nobubble_aluResult_M", aluResult_M);
        check("nobubble_valid_M", 64'(valid_M), 64'd1);
        check("nobubble_state", 64'(state_dbg), 64'(S_IDLE));
        check("st_readData_kept", readData_M, 64'hDEADBEEF);

        // ack in IDLE is ignored
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 64'hBAD;
        @(negedge clk);
        dm_bus.dm_ack = 1'b0;
        check("idle_ack_state", 64'(state_dbg), 64'(S_IDLE));
        check("idle_ack_readData", readData_M, 64'hDEADBEEF);

        // back-to-back loads: second load captured on first ack edge
        r_data = {32'h0, $urandom};
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h18, '0, '0);
        exp_q.push_back(r_data);
        @(negedge clk);
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h20, '0, '0);
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = r_data;
        @(negedge clk);
        nop();
        check_pop("b2b_first_readData", readData_M);
        check("b2b_state", 64'(state_dbg), 64'(S_ACCESS));
        check("b2b_dm_addr", dm_bus.dm_addr, 64'h20);
        r_data = {$urandom, $urandom};
        exp_q.push_back(r_data);
        dm_bus.dm_rdata = r_data;
        @(negedge clk);
        dm_bus.dm_ack = 1'b0;
        check_pop("b2b_second_readData", readData_M);
        check("b2b_state_after", 64'(state_dbg), 64'(S_IDLE));

        // random ALU / branch ops
        for (int i = 0; i < 6; i++) begin
            r_alu = {32'h0, $urandom};
            r_pcb = {32'h0, $urandom};
            r_br  = 1'($urandom_range(0, 1));
            r_z   = 1'($urandom_range(0, 1));
            set_op(1'b1, 1'b0, 1'b0, r_br, r_z, r_alu, '0, r_pcb);
            exp_q.push_back(r_alu);
            @(negedge clk);
            check_pop("rnd_aluResult_M", aluResult_M);
            check("rnd_PCSrc_M", 64'(PCSrc_M), 64'(r_br & r_z));
            check("rnd_PCBranch_M", PCBranch_M, r_pcb);
        end
        nop();
        @(negedge clk);

        // ack arrives exactly in access cycle 16: ack wins
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h200, '0, '0);
        @(negedge clk);
        nop();
        req_cycles = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                dm_bus.dm_ack   = 1'b1;
                dm_bus.dm_rdata = 64'h1234;
                exp_q.push_back(64'h1234);
            end
            #1;
            if (dm_bus.dm_req) req_cycles++;
            @(negedge clk);
        end
        dm_bus.dm_ack = 1'b0;
        check("to16_req_cycles", 64'(req_cycles), 64'd16);
        check("to16_state", 64'(state_dbg), 64'(S_IDLE));
        check("to16_err_M", 64'(err_M), 64'd0);
        check_pop("to16_readData_M", readData_M);

        // no ack at all: fault after 16 access cycles
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h300, '0, '0);
        @(negedge clk);
        nop();
        req_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!dm_bus.dm_req) break;
            req_cycles++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 64'(req_cycles), 64'd16);
        check("tmo_state", 64'(state_dbg), 64'(S_FAULT));
        check("tmo_err_M", 64'(err_M), 64'd1);
        check("tmo_stall_M", 64'(stall_M), 64'd1);
        check("tmo_valid_M", 64'(valid_M), 64'd0);

        // FAULT absorbs new ops and acks
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h99, '0, 64'h44);
        dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        dm_bus.dm_ack = 1'b0;
        nop();
        check("fault_valid_M", 64'(valid_M), 64'd0);
        check("fault_PCSrc_M", 64'(PCSrc_M), 64'd0);
        check("fault_aluResult_held", aluResult_M, 64'h300);
        check("fault_state", 64'(state_dbg), 64'(S_FAULT));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("fault_rst_err_M", 64'(err_M), 64'd0);
        check("fault_rst_state", 64'(state_dbg), 64'(S_IDLE));

        // misaligned load: fault without any request
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h104, '0, '0);
        @(negedge clk);
        nop();
        req_seen = 1'b0;
        repeat (4) begin
            #1;
            if (dm_bus.dm_req) req_seen = 1'b1;
            @(negedge clk);
        end
        check("mis_req_seen", 64'(req_seen), 64'd0);
        check("mis_err_M", 64'(err_M), 64'd1);
        check("mis_state", 64'(state_dbg), 64'(S_FAULT));
        check("mis_valid_M", 64'(valid_M), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mis_rst_err_M", 64'(err_M), 64'd0);
        check("mis_rst_state", 64'(state_dbg), 64'(S_IDLE));

        // reset during ACCESS abandons the request, even with a same-cycle ack
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10, '0, '0);
        @(negedge clk);
        nop();
        check("rsta_dm_req_before", 64'(dm_bus.dm_req), 64'd1);
        reset = 1'b1;
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = 64'hFFFF;
        @(negedge clk);
        reset = 1'b0;
        check("rsta_dm_req", 64'(dm_bus.dm_req), 64'd0);
        check("rsta_state", 64'(state_dbg), 64'(S_IDLE));
        check("rsta_readData", readData_M, 64'd0);
        @(negedge clk);
        dm_bus.dm_ack = 1'b0;
        check("rsta_late_ack_state", 64'(state_dbg), 64'(S_IDLE));
        check("rsta_late_ack_readData", readData_M, 64'd0);

        // final report
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
